// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Contents: FSM state codes and enum, default operand width, clog2 helper.
package mult_pkg;

  localparam int unsigned MULT_W_DEF = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_BUSY = ST_BUSY,
    S_DONE = ST_DONE
  } state_t;

  // Ceiling log2, usable in constant expressions
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_shift_add_mult_if.sv
// Handshake bundle of the shift-add multiplier.
//   i_valid/i_ready/A/B : operand channel (master drives i_valid, A, B)
//   o_valid/o_ready/P   : product channel (master drives o_ready)
//   busy                : status, high while iterating
// Modports: master (stimulus side), slave (multiplier side).
interface seq_shift_add_mult_if #(
  parameter int unsigned WIDTH = mult_pkg::MULT_W_DEF
);

  logic                 i_valid;
  logic                 i_ready;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 o_valid;
  logic                 o_ready;
  logic [2*WIDTH-1:0]   P;
  logic                 busy;

  modport master (
    output i_valid, A, B, o_ready,
    input  i_ready, o_valid, P, busy
  );

  modport slave (
    input  i_valid, A, B, o_ready,
    output i_ready, o_valid, P, busy
  );

endinterface

// File: rtl/mult_operand_shifter.sv
// Operand shift registers for the shift-add multiplier.
//   clk, rst_n : clock, async active-low reset
//   load       : capture AS={0,A}, BS=B
//   step       : AS<<=1, BS>>=1 (load has priority)
//   A, B       : operands (already in magnitude form)
//   AS, BS     : registered shifted multiplicand / multiplier
module mult_operand_shifter
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   AS,
  output logic [WIDTH-1:0]     BS
);

  // Load-or-shift registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      AS <= '0;
      BS <= '0;
    end else if (load) begin
      AS <= {{WIDTH{1'b0}}, A};
      BS <= B;
    end else if (step) begin
      AS <= {AS[2*WIDTH-2:0], 1'b0};
      BS <= {1'b0, BS[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier with valid/ready on operand and product sides.
// Accepts A,B in IDLE, performs WIDTH add/shift steps in BUSY, then holds the
// 2*WIDTH-bit product in DONE until o_ready.
//   clk, rst_n : clock, async active-low reset
//   bus        : seq_shift_add_mult_if.slave (i_valid/i_ready/A/B, o_valid/o_ready/P, busy)
// Build option: MULT_SIGNED_EN selects two's-complement operands and product
// (magnitudes are multiplied, the sign is applied to the final product).
module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seq_shift_add_mult_if.slave   bus
);

  localparam int unsigned PW       = 2 * WIDTH;
  localparam int unsigned CNT_W    = clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt;
  logic [PW-1:0]      acc;
  logic [PW-1:0]      acc_step;
  logic [PW-1:0]      as_q;
  logic [WIDTH-1:0]   bs_q;
  logic [WIDTH-1:0]   a_ld;
  logic [WIDTH-1:0]   b_ld;
  logic [PW-1:0]      p_final;
  logic               load;
  logic               step;
  logic               last;
  logic               unused_bs;

  // i_ready is high exactly in IDLE, so the handshake reduces to IDLE && i_valid
  assign load = (state == S_IDLE) && bus.i_valid;
  assign step = (state == S_BUSY);
  assign last = step && (cnt == CNT_LAST);

  // One shift-add step; wraps modulo 2^PW
  assign acc_step = acc + (bs_q[0] ? as_q : '0);

  // Only the LSB of the multiplier register feeds the adder
  assign unused_bs = ^bs_q[WIDTH-1:1];

`ifdef MULT_SIGNED_EN
  logic neg;

  // Magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1), which fits unsigned
  assign a_ld    = bus.A[WIDTH-1] ? (~bus.A + WIDTH'(1)) : bus.A;
  assign b_ld    = bus.B[WIDTH-1] ? (~bus.B + WIDTH'(1)) : bus.B;
  assign p_final = neg ? (~acc_step + PW'(1)) : acc_step;

  // Result sign captured with the operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg <= 1'b0;
    end else if (load) begin
      neg <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
    end
  end
`else
  assign a_ld    = bus.A;
  assign b_ld    = bus.B;
  assign p_final = acc_step;
`endif

  mult_operand_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .step  (step),
    .A     (a_ld),
    .B     (b_ld),
    .AS    (as_q),
    .BS    (bs_q)
  );

  // Next-state logic
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:  if (bus.i_valid)        state_d = S_BUSY;
      S_BUSY:  if (cnt == CNT_LAST)    state_d = S_DONE;
      S_DONE:  if (bus.o_ready)        state_d = S_IDLE;
      default:                         state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs (outputs decoded from next state)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      acc         <= '0;
      bus.i_ready <= 1'b1;
      bus.o_valid <= 1'b0;
      bus.busy    <= 1'b0;
      bus.P       <= '0;
    end else begin
      state       <= state_d;
      bus.i_ready <= (state_d == S_IDLE);
      bus.o_valid <= (state_d == S_DONE);
      bus.busy    <= (state_d == S_BUSY);
      if (load) begin
        acc <= '0;
        cnt <= '0;
      end else if (step) begin
        acc <= acc_step;
        cnt <= cnt + CNT_W'(1);
      end
      // P only changes on entry to DONE
      if (last) begin
        bus.P <= p_final;
      end
    end
  end

endmodule
